// File: rtl/xor_arbiter.sv
// rtl/xor_arbiter.sv - two-requester round-robin arbiter feeding one shared XOR datapath
//
// xor_gate    : combinational WIDTH-bit bitwise XOR, the shared datapath.
// xor_arbiter : top level.
//   clk                 rising-edge clock, sole clock domain
//   rst                 synchronous active-high reset
//   req0_valid/_a/_b    requester 0 operand pair and its valid
//   req1_valid/_a/_b    requester 1 operand pair and its valid
//   req0_ready          requester 0 pair accepted this cycle (valid & ready)
//   req1_ready          requester 1 pair accepted this cycle (valid & ready)
//   res_valid           result register holds an undelivered result
//   res_data            registered a XOR b of the accepted pair
//   res_id              requester index that owns res_data
//   res_ready           consumer takes the result when res_valid & res_ready
//   cnt0, cnt1          (only with XOR_ARB_COUNT_EN) saturating 8-bit accept
//                       counters per requester
// Optional feature macro: XOR_ARB_COUNT_EN.

module xor_gate #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = a ^ b;

endmodule

module xor_arbiter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req0_ready,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
`ifdef XOR_ARB_COUNT_EN
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
`endif
    input  logic             res_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_id_q, res_id_d;

    logic             grant;
    logic             grant_valid;
    logic             accept_ok;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] xor_y;

    // Round-robin grant: a lone requester always wins; on a tie the one
    // that did not win last time is chosen.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign grant_valid = grant ? req1_valid : req0_valid;

    // The result register can take a new value when empty, or when its
    // current value is being drained in this same cycle.
    assign accept_ok = (state_q == IDLE) || res_ready;
    assign accept    = accept_ok && grant_valid && !rst;

    // Operand mux in front of the single shared XOR instance.
    assign op_a = grant ? req1_a : req0_a;
    assign op_b = grant ? req1_b : req0_b;

    xor_gate #(
        .WIDTH (WIDTH)
    ) u_xor_gate (
        .a (op_a),
        .b (op_b),
        .y (xor_y)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_d = HOLD;
                end else if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture on accept; otherwise hold so the result stays stable while
    // the consumer stalls.
    always_comb begin
        last_grant_d = last_grant_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        if (accept) begin
            last_grant_d = grant;
            res_data_d   = xor_y;
            res_id_d     = grant;
        end
    end

    // Output logic. Ready is qualified by the requester's own valid so an
    // idle requester never sees ready, and is forced low during reset.
    always_comb begin
        req0_ready = accept_ok && !grant && req0_valid && !rst;
        req1_ready = accept_ok &&  grant && req1_valid && !rst;
        res_valid  = (state_q == HOLD);
        res_data   = res_data_q;
        res_id     = res_id_q;
    end

`ifdef XOR_ARB_COUNT_EN
    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    // Saturating accept counters.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (accept && !grant && (cnt0_q != 8'hFF)) begin
            cnt0_d = cnt0_q + 8'd1;
        end
        if (accept && grant && (cnt1_q != 8'hFF)) begin
            cnt1_d = cnt1_q + 8'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_xor_arbiter.sv
// tb/tb_xor_arbiter.sv - scoreboard testbench for xor_arbiter

module tb_xor_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         res_id;
    logic         res_ready;
`ifdef XOR_ARB_COUNT_EN
    logic [7:0]   cnt0, cnt1;
`endif

    int checks = 0;
    int errors = 0;

    // Expected results in delivery order: {id, data}.
    logic [W:0] exp_q[$];
    logic       m_hold;
    logic       m_last;

    always #5 clk = ~clk;

    xor_arbiter #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
`ifdef XOR_ARB_COUNT_EN
        .cnt0       (cnt0),
        .cnt1       (cnt1),
`endif
        .res_ready  (res_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle of stimulus with checks against the reference model.
    task automatic drive(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input logic rr);
        logic ok, g, e0, e1;
        @(negedge clk);
        rst        = 1'b0;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        res_ready  = rr;
        #1;
        ok = !m_hold || rr;
        g  = (v0 && v1) ? ~m_last : v1;
        e0 = ok && v0 && !g;
        e1 = ok && v1 && g;
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        check("res_valid", res_valid, m_hold);
        if (m_hold) begin
            check("res_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check("res_id_data", {res_id, res_data}, exp_q[0]);
                if (rr) void'(exp_q.pop_front());
            end
        end
        if (e0) begin
            exp_q.push_back({1'b0, a0 ^ b0});
            m_last = 1'b0;
        end else if (e1) begin
            exp_q.push_back({1'b1, a1 ^ b1});
            m_last = 1'b1;
        end
        if (e0 || e1) m_hold = 1'b1;
        else if (rr) m_hold = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
        req1_valid = 1'b1; req1_a = 8'h56; req1_b = 8'h78;
        res_ready  = 1'b1;
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_id", res_id, 0);
`ifdef XOR_ARB_COUNT_EN
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
`endif
        exp_q.delete();
        m_hold = 1'b0;
        m_last = 1'b1;
    endtask

    initial begin
        logic [W-1:0] pa [4];
        logic [W-1:0] pb [4];
        pa[0] = 8'd0; pb[0] = 8'd0;
        pa[1] = 8'd1; pb[1] = 8'd1;
        pa[2] = 8'd0; pb[2] = 8'd1;
        pa[3] = 8'd1; pb[3] = 8'd0;

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        res_ready = 1'b0;
        m_hold = 1'b0;
        m_last = 1'b1;

        // Single accept on requester 0, result one cycle later.
        do_reset();
        drive(1, 8'd1, 8'd0, 0, 8'd0, 8'd0, 1);
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);

        // Continuous tie: grants alternate starting with requester 0.
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, pa[i], pb[i], 1, pa[i], pb[i], 1);
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);

        // Back-pressure: result held stable, no ready while stalled.
        drive(1, 8'h3C, 8'h0F, 0, 8'd0, 8'd0, 1);
        for (int i = 0; i < 3; i++) drive(1, 8'hFF, 8'h01, 1, 8'h77, 8'h11, 0);
        drive(1, 8'hFF, 8'h01, 1, 8'h77, 8'h11, 1);
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);

        // Wide XOR on requester 1.
        drive(0, 8'd0, 8'd0, 1, 8'hA5, 8'h0F, 1);
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);
        check("wide_xor_delivered", exp_q.size(), 0);

        // Reset while a result is held: it must vanish.
        drive(1, 8'hC3, 8'h81, 0, 8'd0, 8'd0, 0);
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 0);
        do_reset();
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);

        // Randomised traffic with random back-pressure.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 4; i++) drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);
        check("random_drained", exp_q.size(), 0);

        // 300 accepts on requester 0 (saturates the counter when present).
        do_reset();
        for (int i = 0; i < 300; i++) drive(1, 8'(i), 8'h5A, 0, 8'd0, 8'd0, 1);
        drive(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);
`ifdef XOR_ARB_COUNT_EN
        check("cnt0_sat", cnt0, 255);
        check("cnt1_zero", cnt1, 0);
`endif
        check("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_arbiter.md
XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, default 1, operand/result bit width (legal range 1..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req0_valid, req1_valid  input  1  requester has an operand pair pending.
REQ-005 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  WIDTH  requester operands.
REQ-006 SHALL have ports: req0_ready, req1_ready  output  1  operand pair accepted this cycle when valid&ready.
REQ-007 SHALL have port: res_valid  output  1  result register holds an undelivered result.
REQ-008 SHALL have port: res_data  output  WIDTH  registered a XOR b of the accepted pair.
REQ-009 SHALL have port: res_id  output  1  index of the requester that owns res_data.
REQ-010 SHALL have port: res_ready  input  1  consumer takes the result when res_valid&res_ready.

Function
REQ-011 SHALL share one internal xorGate datapath instance between both requesters.
REQ-012 SHALL implement FSM states IDLE (result register empty) and HOLD (result register full).
REQ-013 SHALL define accept_ok = (state==IDLE) or (state==HOLD and res_ready).
REQ-014 SHALL grant round-robin: one requester valid -> grant it; both valid -> grant the one not equal to last_grant.
REQ-015 SHALL drive reqN_ready combinationally = accept_ok and grant==N; at most one ready high per cycle.
REQ-016 SHALL assert reqN_ready only while reqN_valid is high.
REQ-017 SHALL on accept capture a XOR b into res_data, N into res_id, set last_grant=N, next state HOLD; latency 1 cycle.
REQ-018 SHALL transition HOLD->IDLE when res_ready and no accept; HOLD->HOLD with new data on simultaneous drain+accept (throughput 1 result/cycle).
REQ-019 SHALL keep res_data, res_id stable while res_valid and not res_ready.
REQ-020 SHALL set res_valid high exactly in state HOLD.
REQ-021 SHALL ignore res_ready in IDLE and operand changes on non-granted requester.
REQ-022 SHALL compute bitwise XOR over all WIDTH bits, no carry or extension.

Reset
REQ-023 SHALL on rst high at a clock edge: state=IDLE, res_valid=0, res_data=0, res_id=0, last_grant=1 (requester 0 wins first tie).
REQ-024 SHALL drive req0_ready=req1_ready=0 during any cycle rst is high.
REQ-025 SHALL discard a held undelivered result when rst asserts mid-operation; no result emitted for it after reset.

Configuration
REQ-026 SHALL, with macro XOR_ARB_COUNT_EN defined, add outputs cnt0, cnt1 (8 bits each) counting accepts per requester, saturating at 255, reset to 0.
REQ-027 SHALL, without XOR_ARB_COUNT_EN, omit cnt0/cnt1 ports and counter logic; all other behaviour identical.

Verification
REQ-028 SHALL verify: reset, then req0 valid a=1 b=0, res_ready=1 -> req0_ready=1 same cycle, next cycle res_valid=1 res_data=1 res_id=0.
REQ-029 SHALL verify: both valid continuously, res_ready=1, four cycles -> grants 0,1,0,1; results req pairs (0,0),(1,1),(0,1),(1,0) give res_data 0,0,1,1.
REQ-030 SHALL verify: res_ready=0 with result held and both valid -> both ready=0, res_data/res_id unchanged 3 cycles; res_ready=1 -> accept and new result next cycle.
REQ-031 SHALL verify: rst asserted in HOLD with res_valid=1 -> next cycle res_valid=0, res_data=0, state IDLE, ready low during rst.
REQ-032 SHALL verify (XOR_ARB_COUNT_EN): 300 accepts on req0 -> cnt0=255, cnt1=0; WIDTH=8, a=0xA5 b=0x0F -> res_data=0xAA.
